// File: rtl/drive_circuit_inst_issue.sv
// drive_circuit_inst_issue: per-bank instruction issue unit.
// Buffers decoder instruction words in a fall-through FIFO. Each head word's
// start time is compared against a local free-running timer, and words that
// are due are handed to the bank datapath over a valid/ready handshake.
// Optional feature macro: DRIVE_ISSUE_LATE_DROP_EN (discard late heads instead
// of issuing them).
//
// state | meaning
// IDLE  | FIFO empty, nothing pending
// WAIT  | head present but not yet due (or just evaluated)
// ISSUE | output registers hold an instruction, issue_valid_out = 1
module drive_circuit_inst_issue #(
    parameter int QUBIT_ADDR_WIDTH_PER_BANK = 2,
    parameter int START_TIME_WIDTH          = 8,
    parameter int PHASE_WIDTH               = 4,
    parameter int INST_WIDTH_PER_BANK       = QUBIT_ADDR_WIDTH_PER_BANK + START_TIME_WIDTH + 1 + PHASE_WIDTH,
    parameter int FIFO_DEPTH                = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [INST_WIDTH_PER_BANK-1:0]       inst_in,
    input  logic                                 inst_wr_en_in,
    input  logic                                 timer_sync_in,
    input  logic                                 issue_ready_in,
    output logic                                 issue_valid_out,
    output logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] issue_qubit_addr_out,
    output logic                                 issue_z_corr_out,
    output logic [PHASE_WIDTH-1:0]               issue_phase_out,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_count_out,
    output logic                                 overflow_out,
    output logic                                 late_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

`ifdef DRIVE_ISSUE_LATE_DROP_EN
    localparam logic LATE_DROP = 1'b1;
`else
    localparam logic LATE_DROP = 1'b0;
`endif

    logic [INST_WIDTH_PER_BANK-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]                        rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]                        count_q, count_d;
    logic [START_TIME_WIDTH-1:0]          timer_q, timer_d;
    logic [1:0]                           state_q, state_d;
    logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] addr_q;
    logic                                 z_q;
    logic [PHASE_WIDTH-1:0]               phase_q;
    logic                                 overflow_q, late_q;

    logic [INST_WIDTH_PER_BANK-1:0]       head;
    logic [START_TIME_WIDTH-1:0]          head_start, head_diff;
    logic                                 head_late, head_due;
    logic                                 pop, load, late_set, wr_acc;

    assign head       = mem_q[rd_ptr_q];
    assign head_start = head[PHASE_WIDTH+1 +: START_TIME_WIDTH];
    assign head_diff  = head_start - timer_q;
    assign head_late  = head_diff[START_TIME_WIDTH-1];
    assign head_due   = (count_q != '0) && ((head_diff == '0) || head_late);

    // A write into a full FIFO still fits when the head leaves in the same cycle.
    assign wr_acc  = inst_wr_en_in && ((count_q != FULL_COUNT) || pop);
    assign count_d = count_q + CW'(wr_acc) - CW'(pop);
    assign timer_d = timer_sync_in ? '0 : timer_q + 1'b1;

    // Next-state and pop decision; a late head is either issued or discarded.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        load     = 1'b0;
        late_set = 1'b0;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                end else if (head_due) begin
                    pop      = 1'b1;
                    late_set = head_late;
                    if (LATE_DROP && head_late) begin
                        state_d = ST_WAIT;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (issue_ready_in) begin
                    if (head_due) begin
                        pop      = 1'b1;
                        late_set = head_late;
                        if (LATE_DROP && head_late) begin
                            state_d = ST_WAIT;
                        end else begin
                            load    = 1'b1;
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        state_d = (count_q != '0) ? ST_WAIT : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= inst_in;
        end
    end

    // Pointers, occupancy, timer, FSM state, issue registers and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            z_q        <= 1'b0;
            phase_q    <= '0;
            overflow_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            timer_q <= timer_d;
            state_q <= state_d;
            if (load) begin
                addr_q  <= head[INST_WIDTH_PER_BANK-1 -: QUBIT_ADDR_WIDTH_PER_BANK];
                z_q     <= head[PHASE_WIDTH];
                phase_q <= head[PHASE_WIDTH-1:0];
            end
            if (inst_wr_en_in && !wr_acc) overflow_q <= 1'b1;
            if (late_set)                 late_q     <= 1'b1;
        end
    end

    assign issue_valid_out      = (state_q == ST_ISSUE);
    assign issue_qubit_addr_out = addr_q;
    assign issue_z_corr_out     = z_q;
    assign issue_phase_out      = phase_q;
    assign fifo_count_out       = count_q;
    assign overflow_out         = overflow_q;
    assign late_out             = late_q;

endmodule

// File: tb/tb_drive_circuit_inst_issue.sv
// Directed bench for drive_circuit_inst_issue (default parameters).
// Tracks the expected timer value itself and checks outputs 1 time unit after
// each rising edge.
module tb_drive_circuit_inst_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] inst_in = '0;
    logic        inst_wr_en_in = 1'b0;
    logic        timer_sync_in = 1'b0;
    logic        issue_ready_in = 1'b0;
    logic        issue_valid_out;
    logic [1:0]  issue_qubit_addr_out;
    logic        issue_z_corr_out;
    logic [3:0]  issue_phase_out;
    logic [3:0]  fifo_count_out;
    logic        overflow_out;
    logic        late_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] tb_t = '0;

    drive_circuit_inst_issue dut (
        .clk                  (clk),
        .rst                  (rst),
        .inst_in              (inst_in),
        .inst_wr_en_in        (inst_wr_en_in),
        .timer_sync_in        (timer_sync_in),
        .issue_ready_in       (issue_ready_in),
        .issue_valid_out      (issue_valid_out),
        .issue_qubit_addr_out (issue_qubit_addr_out),
        .issue_z_corr_out     (issue_z_corr_out),
        .issue_phase_out      (issue_phase_out),
        .fifo_count_out       (fifo_count_out),
        .overflow_out         (overflow_out),
        .late_out             (late_out)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] word(input int start, input int addr, input int phase, input int z);
        logic [7:0] s;
        logic [1:0] a;
        logic [3:0] p;
        logic       zz;
        s  = 8'(start);
        a  = 2'(addr);
        p  = 4'(phase);
        zz = 1'(z);
        return {a, s, zz, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst || timer_sync_in) tb_t = '0;
        else                      tb_t = tb_t + 8'd1;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input logic [7:0] t);
        int n = 0;
        while (tb_t != t && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            errors++;
            $error("FAIL wait_timeout observed=%0d expected=%0d", tb_t, t);
        end
    endtask

    task automatic check_issue(input string tag, input int addr, input int phase, input int z);
        check({tag, "_valid"}, 32'(issue_valid_out), 32'd1);
        check({tag, "_addr"},  32'(issue_qubit_addr_out), 32'(addr));
        check({tag, "_phase"}, 32'(issue_phase_out), 32'(phase));
        check({tag, "_z"},     32'(issue_z_corr_out), 32'(z));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(issue_valid_out), 32'd0);
        check("rst_count", 32'(fifo_count_out), 32'd0);
        check("rst_ovf",   32'(overflow_out), 32'd0);
        check("rst_late",  32'(late_out), 32'd0);

        // Single word, start_time 5, written while timer = 0
        rst = 1'b0;
        inst_in = word(5, 2, 3, 0);
        inst_wr_en_in = 1'b1;
        tick();
        inst_wr_en_in = 1'b0;
        check("single_count_after_wr", 32'(fifo_count_out), 32'd1);
        check("single_valid_early",    32'(issue_valid_out), 32'd0);
        wait_until(8'd5);
        check("single_valid_t5", 32'(issue_valid_out), 32'd0);
        tick();
        check_issue("single_t6", 2, 3, 0);
        check("single_count_t6", 32'(fifo_count_out), 32'd0);
        issue_ready_in = 1'b1;
        tick();
        check("single_done_valid", 32'(issue_valid_out), 32'd0);
        check("single_done_count", 32'(fifo_count_out), 32'd0);

        // Timer sync at timer = 7, then back-to-back issue of four words
        issue_ready_in = 1'b0;
        timer_sync_in = 1'b1;
        tick();
        timer_sync_in = 1'b0;
        tick();
        tick();
        issue_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            inst_in = word(10 + k, k, k + 1, k & 1);
            inst_wr_en_in = 1'b1;
            tick();
        end
        inst_wr_en_in = 1'b0;
        check("b2b_count_full", 32'(fifo_count_out), 32'd4);
        wait_until(8'd10);
        check("b2b_valid_t10", 32'(issue_valid_out), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_issue($sformatf("b2b_%0d", k), k, k + 1, k & 1);
            check($sformatf("b2b_count_%0d", k), 32'(fifo_count_out), 32'(3 - k));
        end
        tick();
        check("b2b_end_valid", 32'(issue_valid_out), 32'd0);
        check("b2b_end_late",  32'(late_out), 32'd0);

        // Backpressure: first word held while ready is low
        issue_ready_in = 1'b0;
        inst_in = word(20, 1, 5, 1);
        inst_wr_en_in = 1'b1;
        tick();
        inst_in = word(27, 3, 6, 0);
        tick();
        inst_wr_en_in = 1'b0;
        wait_until(8'd20);
        check("bp_valid_t20", 32'(issue_valid_out), 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_issue($sformatf("bp_hold_%0d", i), 1, 5, 1);
            check($sformatf("bp_count_%0d", i), 32'(fifo_count_out), 32'd1);
        end
        issue_ready_in = 1'b1;
        tick();
        check_issue("bp_next", 3, 6, 0);
        check("bp_next_count", 32'(fifo_count_out), 32'd0);
        tick();
        check("bp_end_valid", 32'(issue_valid_out), 32'd0);

        // Overflow: nine writes with no pops, then write plus pop when full
        issue_ready_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            inst_in = word((k == 0) ? 40 : 130, k + 1, k + 1, 0);
            inst_wr_en_in = 1'b1;
            tick();
            check($sformatf("ovf_count_%0d", k), 32'(fifo_count_out), 32'((k < 8) ? k + 1 : 8));
            check($sformatf("ovf_flag_%0d", k), 32'(overflow_out), 32'((k == 8) ? 1 : 0));
        end
        inst_wr_en_in = 1'b0;
        wait_until(8'd40);
        inst_in = word(200, 0, 15, 1);
        inst_wr_en_in = 1'b1;
        tick();
        inst_wr_en_in = 1'b0;
        check("ovf_wrpop_count", 32'(fifo_count_out), 32'd8);
        check_issue("ovf_wrpop_issue", 1, 1, 0);
        check("ovf_sticky", 32'(overflow_out), 32'd1);

        // Reset while in ISSUE discards everything
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(issue_valid_out), 32'd0);
        check("midrst_count", 32'(fifo_count_out), 32'd0);
        check("midrst_ovf",   32'(overflow_out), 32'd0);

        // Wrap-around: start_time 4 written at timer = 250 is future
        issue_ready_in = 1'b1;
        wait_until(8'd250);
        inst_in = word(4, 2, 9, 1);
        inst_wr_en_in = 1'b1;
        tick();
        inst_wr_en_in = 1'b0;
        check("wrap_count", 32'(fifo_count_out), 32'd1);
        wait_until(8'd4);
        check("wrap_valid_t4", 32'(issue_valid_out), 32'd0);
        tick();
        check_issue("wrap_t5", 2, 9, 1);
        check("wrap_late", 32'(late_out), 32'd0);
        tick();
        check("wrap_end_valid", 32'(issue_valid_out), 32'd0);

        // Late head: start_time 200 written at timer = 250
        wait_until(8'd250);
        inst_in = word(200, 3, 10, 0);
        inst_wr_en_in = 1'b1;
        tick();
        inst_wr_en_in = 1'b0;
        tick();
        check("late_flag", 32'(late_out), 32'd1);
        check("late_count", 32'(fifo_count_out), 32'd0);
`ifdef DRIVE_ISSUE_LATE_DROP_EN
        check("late_dropped_valid", 32'(issue_valid_out), 32'd0);
`else
        check_issue("late_issued", 3, 10, 0);
`endif
        tick();
        check("late_end_valid", 32'(issue_valid_out), 32'd0);
        check("late_end_flag",  32'(late_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
